ffsr_spike_driver: RTL and testbench

- Upstream sequencer for the FFSR spike-binary counter stage.
- Accepts burst commands over a valid/ready handshake: a direction plus a pulse count.
- Converts each command into a train of single-cycle spike pulses on spk_en, with the direction held on spk_up. These two outputs drive the counter stage's enable and direction inputs.
- Keeps a saturating shadow of the expected counter value so downstream logic and the bench can check the count without probing the counter.

---
 rtl/ffsr_spike_driver_if.sv | 26 ++
 rtl/ffsr_spike_driver.sv | 147 ++++++++++++++
 tb/tb_ffsr_spike_driver.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ffsr_spike_driver_if.sv
// Command channel for the FFSR spike driver: burst request handshake plus abort.
interface ffsr_spike_driver_if #(
  parameter int CNT_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_up;
  logic [CNT_W-1:0] cmd_mag;
  logic             abort;

  modport master (
    output cmd_valid,
    output cmd_up,
    output cmd_mag,
    output abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_up,
    input  cmd_mag,
    input  abort,
    output cmd_ready
  );
endinterface

// File: rtl/ffsr_spike_driver.sv
// Turns direction/count burst commands into single-cycle spikes for the FFSR counter
// stage, tracking a saturating shadow of the count the counter should now hold.
module ffsr_spike_driver #(
  parameter int W     = 3,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  ffsr_spike_driver_if.slave   cmd,
  output logic                 spk_en,
  output logic                 spk_up,
  output logic                 busy,
  output logic                 done,
  output logic                 sat,
  output logic [W-1:0]         shadow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int               GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0]    GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [W-1:0]     SH_MAX   = '1;
  localparam logic [CNT_W-1:0] REM_ONE  = 1;

  state_t           state_reg, state_next;
  logic             dir_reg, dir_next;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic [GW-1:0]    gap_reg, gap_next;
  logic [W-1:0]     shadow_reg, shadow_next;
  logic             sat_reg, sat_next;
  logic             done_reg, done_next;
  logic             spk_en_reg, spk_en_next;
  logic             spk_up_reg, spk_up_next;
  logic             busy_reg, busy_next;
  logic             cmd_ready_reg, cmd_ready_next;

  always_comb begin
    state_next  = state_reg;
    dir_next    = dir_reg;
    rem_next    = rem_reg;
    gap_next    = gap_reg;
    shadow_next = shadow_reg;
    sat_next    = sat_reg;
    done_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (cmd.cmd_valid && cmd_ready_reg) begin
          dir_next = cmd.cmd_up;
          rem_next = cmd.cmd_mag;
          sat_next = 1'b0;
          if (cmd.cmd_mag != '0) begin
            state_next = S_PULSE;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      S_PULSE: begin
        rem_next = rem_reg - 1'b1;
        // The spike on the wire this cycle always lands, so the shadow follows it
        // even when an abort ends the burst at this edge.
        if (dir_reg) begin
          if (shadow_reg == SH_MAX) sat_next = 1'b1;
          else                      shadow_next = shadow_reg + 1'b1;
        end else begin
          if (shadow_reg == '0) sat_next = 1'b1;
          else                  shadow_next = shadow_reg - 1'b1;
        end
        if (cmd.abort) begin
          state_next = S_IDLE;
          rem_next   = '0;
        end else if (rem_reg == REM_ONE) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else if (GAP > 0) begin
          state_next = S_GAP;
          gap_next   = GAP_LOAD;
        end
      end

      S_GAP: begin
        if (cmd.abort) begin
          state_next = S_IDLE;
          rem_next   = '0;
        end else if (gap_reg == '0) begin
          state_next = S_PULSE;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so the spike lines up with PULSE.
    spk_en_next    = (state_next == S_PULSE);
    spk_up_next    = (state_next == S_PULSE) && dir_next;
    busy_next      = (state_next != S_IDLE);
    cmd_ready_next = (state_next == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      dir_reg       <= 1'b0;
      rem_reg       <= '0;
      gap_reg       <= '0;
      shadow_reg    <= '0;
      sat_reg       <= 1'b0;
      done_reg      <= 1'b0;
      spk_en_reg    <= 1'b0;
      spk_up_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      cmd_ready_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      dir_reg       <= dir_next;
      rem_reg       <= rem_next;
      gap_reg       <= gap_next;
      shadow_reg    <= shadow_next;
      sat_reg       <= sat_next;
      done_reg      <= done_next;
      spk_en_reg    <= spk_en_next;
      spk_up_reg    <= spk_up_next;
      busy_reg      <= busy_next;
      cmd_ready_reg <= cmd_ready_next;
    end
  end

  assign spk_en        = spk_en_reg;
  assign spk_up        = spk_up_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign sat           = sat_reg;
  assign shadow        = shadow_reg;
  assign cmd.cmd_ready = cmd_ready_reg;

endmodule

// File: tb/tb_ffsr_spike_driver.sv
// Directed bench for ffsr_spike_driver: a per-cycle vector table on a GAP=0 instance,
// plus hand sequences for gapped bursts, abort and mid-burst reset.
module tb_ffsr_spike_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ffsr_spike_driver_if #(.CNT_W(4)) if0 ();
  ffsr_spike_driver_if #(.CNT_W(4)) if2 ();

  logic       en0, up0, busy0, done0, sat0;
  logic [2:0] sh0;
  logic       en2, up2, busy2, done2, sat2;
  logic [2:0] sh2;

  ffsr_spike_driver #(.W(3), .CNT_W(4), .GAP(0)) u0 (
    .clk(clk), .rst(rst), .cmd(if0.slave),
    .spk_en(en0), .spk_up(up0), .busy(busy0), .done(done0), .sat(sat0), .shadow(sh0)
  );

  ffsr_spike_driver #(.W(3), .CNT_W(4), .GAP(2)) u2 (
    .clk(clk), .rst(rst), .cmd(if2.slave),
    .spk_en(en2), .spk_up(up2), .busy(busy2), .done(done2), .sat(sat2), .shadow(sh2)
  );

  // Packed observation: {spk_en, spk_up, busy, done, sat, cmd_ready, shadow[2:0]}
  typedef struct {
    logic       v;
    logic       up;
    logic [3:0] mag;
    logic       ab;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [31];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [8:0] e(input logic en, input logic up, input logic bz,
                                   input logic dn, input logic st, input logic rdy,
                                   input logic [2:0] sh);
    return {en, up, bz, dn, st, rdy, sh};
  endfunction

  task automatic set_row(input int i, input logic v, input logic up, input logic [3:0] mag,
                         input logic ab, input logic [8:0] exp);
    tbl[i].v   = v;
    tbl[i].up  = up;
    tbl[i].mag = mag;
    tbl[i].ab  = ab;
    tbl[i].exp = exp;
  endtask

  // spk_up is only meaningful while spk_en is high, so it is masked otherwise.
  task automatic check(input string name, input logic [8:0] act_in, input logic [8:0] exp);
    logic [8:0] act;
    act = act_in;
    if (!exp[8]) act[7] = exp[7];
    total++;
    if (act === exp) begin
      passed++;
      $display("%s: ok (en,up,busy,done,sat,rdy,sh=%b)", name, act);
    end else begin
      $display("FAIL %s: got en,up,busy,done,sat,rdy,sh=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [8:0] obs0();
    return {en0, up0, busy0, done0, sat0, if0.cmd_ready, sh0};
  endfunction

  function automatic logic [8:0] obs2();
    return {en2, up2, busy2, done2, sat2, if2.cmd_ready, sh2};
  endfunction

  task automatic drive0(input logic v, input logic up, input logic [3:0] mag, input logic ab);
    if0.cmd_valid = v;
    if0.cmd_up    = up;
    if0.cmd_mag   = mag;
    if0.abort     = ab;
  endtask

  task automatic drive2(input logic v, input logic up, input logic [3:0] mag, input logic ab);
    if2.cmd_valid = v;
    if2.cmd_up    = up;
    if2.cmd_mag   = mag;
    if2.abort     = ab;
  endtask

  initial begin
    drive0(1'b0, 1'b0, 4'd0, 1'b0);
    drive2(1'b0, 1'b0, 4'd0, 1'b0);

    // Up 3, then down 5 into saturation, abort of a 6-burst, zero burst, up 15 to saturation.
    set_row(0,  1, 1, 4'd3,  0, e(0,0,0,0,0,1,3'd0));
    set_row(1,  0, 0, 4'd0,  0, e(1,1,1,0,0,0,3'd0));
    set_row(2,  0, 0, 4'd0,  0, e(1,1,1,0,0,0,3'd1));
    set_row(3,  0, 0, 4'd0,  0, e(1,1,1,0,0,0,3'd2));
    set_row(4,  1, 0, 4'd5,  0, e(0,0,0,1,0,1,3'd3));
    set_row(5,  0, 0, 4'd0,  0, e(1,0,1,0,0,0,3'd3));
    set_row(6,  0, 0, 4'd0,  0, e(1,0,1,0,0,0,3'd2));
    set_row(7,  0, 0, 4'd0,  0, e(1,0,1,0,0,0,3'd1));
    set_row(8,  0, 0, 4'd0,  0, e(1,0,1,0,0,0,3'd0));
    set_row(9,  0, 0, 4'd0,  0, e(1,0,1,0,1,0,3'd0));
    set_row(10, 1, 1, 4'd6,  0, e(0,0,0,1,1,1,3'd0));
    set_row(11, 0, 0, 4'd0,  0, e(1,1,1,0,0,0,3'd0));
    set_row(12, 0, 0, 4'd0,  1, e(1,1,1,0,0,0,3'd1));
    set_row(13, 1, 1, 4'd0,  1, e(0,0,0,0,0,1,3'd2));
    set_row(14, 1, 1, 4'd15, 0, e(0,0,0,1,0,1,3'd2));
    for (int i = 15; i <= 20; i++)
      set_row(i, 1, 0, 4'd1, 0, e(1,1,1,0,0,0,3'(i - 13)));
    for (int i = 21; i <= 28; i++)
      set_row(i, 1, 0, 4'd1, 0, e(1,1,1,0,1,0,3'd7));
    set_row(29, 0, 0, 4'd0,  0, e(1,1,1,0,1,0,3'd7));
    set_row(30, 0, 0, 4'd0,  0, e(0,0,0,1,1,1,3'd7));

    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      check($sformatf("row%0d", i), obs0(), tbl[i].exp);
      drive0(tbl[i].v, tbl[i].up, tbl[i].mag, tbl[i].ab);
    end

    // GAP=2 instance: up-2 burst with valid held high, then abort mid down-burst.
    @(negedge clk); check("gap_idle",  obs2(), e(0,0,0,0,0,1,3'd0)); drive2(1, 1, 4'd2, 0);
    @(negedge clk); check("gap_p1",    obs2(), e(1,1,1,0,0,0,3'd0)); drive2(1, 0, 4'd7, 0);
    @(negedge clk); check("gap_g1",    obs2(), e(0,0,1,0,0,0,3'd1));
    @(negedge clk); check("gap_g2",    obs2(), e(0,0,1,0,0,0,3'd1));
    @(negedge clk); check("gap_p2",    obs2(), e(1,1,1,0,0,0,3'd1));
    @(negedge clk); check("gap_done",  obs2(), e(0,0,0,1,0,1,3'd2));
    @(negedge clk); check("gap_held",  obs2(), e(1,0,1,0,0,0,3'd2)); drive2(0, 0, 4'd0, 1);
    @(negedge clk); check("gap_abort", obs2(), e(0,0,0,0,0,1,3'd1)); drive2(0, 0, 4'd0, 0);
    @(negedge clk); check("gap_quiet", obs2(), e(0,0,0,0,0,1,3'd1));

    // Reset in the middle of a down-burst on the GAP=0 instance.
    @(negedge clk); check("rst_pre",   obs0(), e(0,0,0,0,1,1,3'd7)); drive0(1, 0, 4'd4, 0);
    @(negedge clk); check("rst_p1",    obs0(), e(1,0,1,0,0,0,3'd7)); drive0(0, 0, 4'd0, 0);
    @(negedge clk); check("rst_p2",    obs0(), e(1,0,1,0,0,0,3'd6)); rst = 1'b0;
    @(negedge clk); check("rst_hit",   obs0(), e(0,0,0,0,0,1,3'd0)); rst = 1'b1;
    @(negedge clk); check("rst_hold",  obs0(), e(0,0,0,0,0,1,3'd0)); drive0(1, 1, 4'd1, 0);
    @(negedge clk); check("rst_next",  obs0(), e(1,1,1,0,0,0,3'd0)); drive0(0, 0, 4'd0, 0);
    @(negedge clk); check("rst_done",  obs0(), e(0,0,0,1,0,1,3'd1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
